// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU result and control for the memory stage,
// owns the V/N/Z condition flags and the halt sequencer. Optional EX_MEM_PERF_CNT_EN adds stall/bubble counters.
module ex_mem_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_in,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_v,
   input  logic          alu_n,
   input  logic [3:0]    alu_ctrl,
   input  logic          flag_we,
   input  logic [RW-1:0] dst_in,
   input  logic          reg_we_in,
   input  logic          mem_re_in,
   input  logic          mem_we_in,
   input  logic [DW-1:0] store_data_in,
   input  logic          halt_in,
   input  logic          stall,
   input  logic          flush,
   output logic          valid_out,
   output logic [DW-1:0] result_out,
   output logic [RW-1:0] dst_out,
   output logic          reg_we_out,
   output logic          mem_re_out,
   output logic          mem_we_out,
   output logic [DW-1:0] store_data_out,
   output logic          flag_v,
   output logic          flag_n,
   output logic          flag_z,
   output logic          halted
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      HALT_PEND = 2'b01,
      HALTED    = 2'b10
   } state_t;

   state_t state_reg, state_next;

   logic          valid_reg, reg_we_reg, mem_re_reg, mem_we_reg;
   logic [DW-1:0] result_reg, store_data_reg;
   logic [RW-1:0] dst_reg;
   logic          flag_v_reg, flag_n_reg, flag_z_reg;

   logic cap;
   logic is_addsub;
   logic result_zero;

   assign cap         = valid_in & ~stall & ~flush & (state_reg == RUN);
   assign is_addsub   = (alu_ctrl == 4'b0000) | (alu_ctrl == 4'b0001);
   assign result_zero = (alu_result == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Once the halt is latched it commits on the next non-stalled edge; flush cannot undo it.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:       if (cap && halt_in) state_next = HALT_PEND;
         HALT_PEND: if (!stall) state_next = HALTED;
         HALTED:    state_next = HALTED;
         default:   state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg      <= 1'b0;
         reg_we_reg     <= 1'b0;
         mem_re_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         result_reg     <= '0;
         store_data_reg <= '0;
         dst_reg        <= '0;
      end else if (!stall && state_reg != HALTED) begin
         if (cap) begin
            valid_reg      <= 1'b1;
            result_reg     <= alu_result;
            store_data_reg <= store_data_in;
            dst_reg        <= dst_in;
            // HLT travels down the pipe as a valid slot with no side effects.
            reg_we_reg     <= reg_we_in & ~halt_in;
            mem_re_reg     <= mem_re_in & ~halt_in;
            mem_we_reg     <= mem_we_in & ~halt_in;
         end else begin
            valid_reg  <= 1'b0;
            reg_we_reg <= 1'b0;
            mem_re_reg <= 1'b0;
            mem_we_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_v_reg <= 1'b0;
         flag_n_reg <= 1'b0;
         flag_z_reg <= 1'b0;
      end else if (cap && flag_we) begin
         flag_z_reg <= result_zero;
         if (is_addsub) begin
            flag_v_reg <= alu_v;
            flag_n_reg <= alu_n;
         end
      end
   end

   assign valid_out      = valid_reg;
   assign result_out     = result_reg;
   assign dst_out        = dst_reg;
   assign reg_we_out     = reg_we_reg;
   assign mem_re_out     = mem_re_reg;
   assign mem_we_out     = mem_we_reg;
   assign store_data_out = store_data_reg;
   assign flag_v         = flag_v_reg;
   assign flag_n         = flag_n_reg;
   assign flag_z         = flag_z_reg;
   assign halted         = (state_reg == HALTED);

`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0] stall_cnt_reg, bubble_cnt_reg;
   logic        bubble_ins;

   assign bubble_ins = ~stall & (state_reg == RUN) & (flush | ~valid_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else if (state_reg != HALTED) begin
         if (stall && stall_cnt_reg != 16'hFFFF)
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         if (bubble_ins && bubble_cnt_reg != 16'hFFFF)
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

   localparam int DW = 16;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in;
   logic [DW-1:0] alu_result;
   logic          alu_v, alu_n;
   logic [3:0]    alu_ctrl;
   logic          flag_we;
   logic [RW-1:0] dst_in;
   logic          reg_we_in, mem_re_in, mem_we_in;
   logic [DW-1:0] store_data_in;
   logic          halt_in, stall, flush;
   logic          valid_out;
   logic [DW-1:0] result_out;
   logic [RW-1:0] dst_out;
   logic          reg_we_out, mem_re_out, mem_we_out;
   logic [DW-1:0] store_data_out;
   logic          flag_v, flag_n, flag_z, halted;
`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0]   stall_cnt, bubble_cnt;
`endif

   int checks_cnt   = 0;
   int failures_cnt = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
      .alu_v(alu_v), .alu_n(alu_n), .alu_ctrl(alu_ctrl), .flag_we(flag_we),
      .dst_in(dst_in), .reg_we_in(reg_we_in), .mem_re_in(mem_re_in),
      .mem_we_in(mem_we_in), .store_data_in(store_data_in), .halt_in(halt_in),
      .stall(stall), .flush(flush), .valid_out(valid_out), .result_out(result_out),
      .dst_out(dst_out), .reg_we_out(reg_we_out), .mem_re_out(mem_re_out),
      .mem_we_out(mem_we_out), .store_data_out(store_data_out),
      .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z), .halted(halted)
`ifdef EX_MEM_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         failures_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic v, input logic n, input logic z);
      check({tag, ".flags"}, {29'd0, flag_v, flag_n, flag_z}, {29'd0, v, n, z});
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 0; alu_result = '0; alu_v = 0; alu_n = 0;
      alu_ctrl = '0; flag_we = 0; dst_in = '0; reg_we_in = 0; mem_re_in = 0;
      mem_we_in = 0; store_data_in = '0; halt_in = 0; stall = 0; flush = 0;
      #23;
      check("rst.valid", {31'd0, valid_out}, 32'd0);
      check("rst.result", {16'd0, result_out}, 32'd0);
      check_flags("rst", 0, 0, 0);
      check("rst.halted", {31'd0, halted}, 32'd0);
      rst_n = 1'b1;
      #10;

      // 1: SUB giving zero with overflow
      valid_in = 1; alu_ctrl = 4'b0001; alu_result = 16'h0000; alu_v = 1; alu_n = 0;
      flag_we = 1; reg_we_in = 1; dst_in = 4'd3;
      step();
      check("t1.valid", {31'd0, valid_out}, 32'd1);
      check("t1.result", {16'd0, result_out}, 32'h0);
      check("t1.dst", {28'd0, dst_out}, 32'd3);
      check("t1.reg_we", {31'd0, reg_we_out}, 32'd1);
      check_flags("t1", 1, 0, 1);

      // 2: XOR only updates Z
      alu_ctrl = 4'b0110; alu_result = 16'h8001; alu_v = 0; alu_n = 1;
      step();
      check("t2.result", {16'd0, result_out}, 32'h8001);
      check_flags("t2", 1, 0, 0);

      // 2b: code 0010 is not ADD/SUB, V/N hold
      alu_ctrl = 4'b0010; alu_result = 16'h0000;
      step();
      check_flags("t2b", 1, 0, 1);

      // 3: ADD held off by a 3-cycle stall
      alu_ctrl = 4'b0000; alu_result = 16'h1234; alu_v = 0; alu_n = 1; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t3.stall%0d.result", i), {16'd0, result_out}, 32'h0000);
         check_flags($sformatf("t3.stall%0d", i), 1, 0, 1);
      end
      stall = 0;
      step();
      check("t3.result", {16'd0, result_out}, 32'h1234);
      check_flags("t3", 0, 1, 0);

      // 4: flushed flag-setter leaves flags alone
      alu_result = 16'h0000; alu_v = 1; alu_n = 0; flush = 1;
      step();
      check("t4.valid", {31'd0, valid_out}, 32'd0);
      check("t4.reg_we", {31'd0, reg_we_out}, 32'd0);
      check_flags("t4", 0, 1, 0);
      flush = 0; flag_we = 0; alu_result = 16'h5555;
      step();
      check("t4.cap.valid", {31'd0, valid_out}, 32'd1);
      check("t4.cap.result", {16'd0, result_out}, 32'h5555);
      stall = 1; flush = 1; alu_result = 16'h7777;
      step();
      check("t4.sf.valid", {31'd0, valid_out}, 32'd1);
      check("t4.sf.reg_we", {31'd0, reg_we_out}, 32'd1);
      check("t4.sf.result", {16'd0, result_out}, 32'h5555);
      stall = 0; flush = 0;

      // 5: store then bubble
      reg_we_in = 0; mem_we_in = 1; store_data_in = 16'hBEEF; alu_result = 16'h0040;
      step();
      check("t5.mem_we", {31'd0, mem_we_out}, 32'd1);
      check("t5.sdata", {16'd0, store_data_out}, 32'hBEEF);
      check("t5.result", {16'd0, result_out}, 32'h0040);
      check("t5.reg_we", {31'd0, reg_we_out}, 32'd0);
      valid_in = 0;
      step();
      check("t5.bub.mem_we", {31'd0, mem_we_out}, 32'd0);
      check("t5.bub.valid", {31'd0, valid_out}, 32'd0);
      // load path
      valid_in = 1; mem_we_in = 0; mem_re_in = 1; alu_result = 16'h0042;
      step();
      check("t5.ld.mem_re", {31'd0, mem_re_out}, 32'd1);
      check("t5.ld.mem_we", {31'd0, mem_we_out}, 32'd0);

      // 6: halt sequencing
      halt_in = 1; reg_we_in = 1; mem_re_in = 1; mem_we_in = 1; alu_result = 16'h0099;
      step();
      check("t6.pend.valid", {31'd0, valid_out}, 32'd1);
      check("t6.pend.wes", {29'd0, reg_we_out, mem_re_out, mem_we_out}, 32'd0);
      check("t6.pend.halted", {31'd0, halted}, 32'd0);
      halt_in = 0; flush = 1;
      step();
      check("t6.halted", {31'd0, halted}, 32'd1);
      check("t6.h.valid", {31'd0, valid_out}, 32'd0);
      flush = 0; flag_we = 1; alu_ctrl = 4'b0000; alu_result = 16'h0000; alu_v = 1; alu_n = 0;
      step();
      step();
      check("t6.ign.valid", {31'd0, valid_out}, 32'd0);
      check("t6.ign.wes", {29'd0, reg_we_out, mem_re_out, mem_we_out}, 32'd0);
      check_flags("t6.ign", 0, 1, 0);
      check("t6.ign.halted", {31'd0, halted}, 32'd1);
      #2 rst_n = 1'b0;
      #2;
      check("t6.rst.halted", {31'd0, halted}, 32'd0);
      check_flags("t6.rst", 0, 0, 0);
      rst_n = 1'b1;
      flag_we = 0; mem_re_in = 0; mem_we_in = 0; alu_result = 16'h00AA;
      step();
      check("t6.run.valid", {31'd0, valid_out}, 32'd1);
      check("t6.run.result", {16'd0, result_out}, 32'h00AA);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule
